// File: rtl/ws2812_multi_strip_driver.sv
// rtl/ws2812_multi_strip_driver.sv - parallel WS2812 driver for CHANNELS strips sharing one frame memory
//
// Purpose: streams GRB pixel bytes from a shared frame-memory read port to CHANNELS
// WS2812 strips at once. Byte lane c of mem_rdata feeds strip c. Supports one-shot
// frames (start pulse), back-to-back frames (auto_run level) and a per-channel
// enable mask that is latched at each frame start.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         one-cycle request for a single frame (ignored while busy)
//   auto_run      level; frames repeat back-to-back while high
//   enable_mask   per-channel enable, latched when a frame starts
//   mem_rd        frame-memory read enable (single-cycle pulses)
//   mem_addr      frame-memory read address
//   mem_rdata     read data, valid one clock after mem_rd; lane c = channel c
//   busy          high while a frame is in progress, including the latch gap
//   frame_done    one-cycle pulse after the latch gap completes
//   led_do        registered strip data outputs
module ws2812_multi_strip_driver #(
  parameter int CHANNELS         = 4,
  parameter int LEDS_PER_CHANNEL = 160,
  parameter int ADDR_W           = 13,
  parameter int T_TOTAL          = 70,
  parameter int T0H              = 20,
  parameter int T1H              = 50,
  parameter int T_LATCH          = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    auto_run,
  input  logic [CHANNELS-1:0]     enable_mask,
  output logic                    mem_rd,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [CHANNELS*8-1:0]   mem_rdata,
  output logic                    busy,
  output logic                    frame_done,
  output logic [CHANNELS-1:0]     led_do
);

  localparam int NUM_BYTES = 3 * LEDS_PER_CHANNEL;
  localparam int CW        = $clog2(T_TOTAL);
  localparam int LW        = $clog2(T_LATCH + 1);

  localparam logic [CW-1:0]     T_LAST    = CW'(T_TOTAL - 1);
  localparam logic [CW-1:0]     T0H_C     = CW'(T0H);
  localparam logic [CW-1:0]     T1H_C     = CW'(T1H);
  localparam logic [LW-1:0]     L_LAST    = LW'(T_LATCH - 1);
  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD1,
    LOAD2,
    SEND,
    LATCH
  } state_t;

  state_t state, state_d;

  logic [CW-1:0]               cnt;
  logic [2:0]                  bit_idx;
  logic [ADDR_W-1:0]           byte_idx;
  logic [LW-1:0]               lcnt;
  logic [CHANNELS-1:0]         en_q;
  logic [CHANNELS-1:0][7:0]    shift_q;
  logic [CHANNELS-1:0][7:0]    next_q;
  logic                        rd_pend;
  logic [CHANNELS-1:0]         hi;

  logic bit_end, last_byte, latch_end, frame_start;

  assign bit_end     = (cnt == T_LAST);
  assign last_byte   = (byte_idx == LAST_BYTE);
  assign latch_end   = (lcnt == L_LAST);
  // Entering LOAD1 from IDLE or from the end of LATCH marks a new frame.
  assign frame_start = (state_d == LOAD1) && (state != LOAD1);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d  = state;
    mem_rd   = 1'b0;
    mem_addr = '0;
    case (state)
      IDLE: begin
        if (start || auto_run) begin
          state_d = LOAD1;
        end
      end
      LOAD1: begin
        mem_rd  = 1'b1;
        state_d = LOAD2;
      end
      LOAD2: begin
        state_d = SEND;
      end
      SEND: begin
        // Prefetch the next byte at the start of the MSB so it is ready long
        // before the byte boundary.
        if ((cnt == '0) && (bit_idx == 3'd7) && !last_byte) begin
          mem_rd   = 1'b1;
          mem_addr = byte_idx + ADDR_W'(1);
        end
        if (bit_end && (bit_idx == 3'd0) && last_byte) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        if (latch_end) begin
          state_d = auto_run ? LOAD1 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hi = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      hi[c] = (state == SEND) && en_q[c] && (cnt < (shift_q[c][7] ? T1H_C : T0H_C));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      lcnt       <= '0;
      en_q       <= '0;
      shift_q    <= '0;
      next_q     <= '0;
      rd_pend    <= 1'b0;
      frame_done <= 1'b0;
      led_do     <= '0;
    end else begin
      frame_done <= (state == LATCH) && latch_end;
      led_do     <= hi;
      rd_pend    <= (state == SEND) && mem_rd;
      if (rd_pend) begin
        next_q <= mem_rdata;
      end
      if (frame_start) begin
        en_q <= enable_mask;
      end
      case (state)
        LOAD1: begin
          cnt      <= '0;
          bit_idx  <= 3'd7;
          byte_idx <= '0;
          lcnt     <= '0;
        end
        LOAD2: begin
          shift_q <= mem_rdata;
        end
        SEND: begin
          lcnt <= '0;
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd0) begin
              bit_idx <= 3'd7;
              shift_q <= next_q;
              if (!last_byte) begin
                byte_idx <= byte_idx + ADDR_W'(1);
              end
            end else begin
              bit_idx <= bit_idx - 3'd1;
              for (int c = 0; c < CHANNELS; c++) begin
                shift_q[c] <= {shift_q[c][6:0], 1'b0};
              end
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        LATCH: begin
          if (!latch_end) begin
            lcnt <= lcnt + LW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
